// File: rtl/fft_pkg.sv
// Shared definitions for the FFT frame arbiter: FSM state encoding and frame-length helper.
package fft_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int NUM_SRC = 4;

    function automatic int nfft(input int size_buffer);
        return 1 << size_buffer;
    endfunction

endpackage

// File: rtl/fft_frame_arbiter_if.sv
// Source-side and FFT-side handshake bundle of the frame arbiter.
interface fft_frame_arbiter_if #(
    parameter int DATA_FFT_SIZE = 16
) ();
    logic [3:0]                   i_req;
    logic [3:0]                   i_valid;
    logic [4*DATA_FFT_SIZE-1:0]   i_data_i;
    logic [4*DATA_FFT_SIZE-1:0]   i_data_q;
    logic [3:0]                   o_ready;
    logic [3:0]                   o_grant;
    logic                         i_fft_ready;
    logic                         o_fft_valid;
    logic [DATA_FFT_SIZE-1:0]     o_fft_data_i;
    logic [DATA_FFT_SIZE-1:0]     o_fft_data_q;
    logic [1:0]                   o_frame_src;
    logic                         o_frame_done;
    logic                         o_busy;

    // The arbiter side.
    modport slave (
        input  i_req, i_valid, i_data_i, i_data_q, i_fft_ready,
        output o_ready, o_grant, o_fft_valid, o_fft_data_i, o_fft_data_q,
               o_frame_src, o_frame_done, o_busy
    );

    // The sources plus FFT core side.
    modport master (
        output i_req, i_valid, i_data_i, i_data_q, i_fft_ready,
        input  o_ready, o_grant, o_fft_valid, o_fft_data_i, o_fft_data_q,
               o_frame_src, o_frame_done, o_busy
    );
endinterface

// File: rtl/rr_arb4.sv
// Combinational 4-way round-robin pick: first set request after 'last', wrapping mod 4.
module rr_arb4 (
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic [3:0] gnt_onehot,
    output logic [1:0] gnt_idx,
    output logic       any
);
    logic [1:0] cand;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        cand       = '0;
        any        = |req;
        // Scan from farthest to nearest so the nearest requester after 'last' wins.
        for (int k = 4; k >= 1; k--) begin
            cand = last + 2'(k);
            if (req[cand]) begin
                gnt_idx    = cand;
                gnt_onehot = 4'b0001 << cand;
            end
        end
    end
endmodule

// File: rtl/fft_frame_arbiter.sv
// Grants whole NFFT-sample frames of one of four sources to a shared streaming FFT core.
module fft_frame_arbiter
    import fft_pkg::*;
#(
    parameter int SIZE_BUFFER   = 10,
    parameter int DATA_FFT_SIZE = 16
) (
    input logic                 i_clk,
    input logic                 i_reset,
    fft_frame_arbiter_if.slave  bus
);
    localparam int DW = DATA_FFT_SIZE;
    localparam logic [SIZE_BUFFER-1:0] CNT_LAST = SIZE_BUFFER'(nfft(SIZE_BUFFER) - 1);

    state_t                 state_q, state_d;
    logic [3:0]             grant_q, grant_d;
    logic [1:0]             src_q,   src_d;
    logic [1:0]             last_q,  last_d;
    logic [SIZE_BUFFER-1:0] cnt_q,   cnt_d;

    logic [3:0]    arb_onehot;
    logic [1:0]    arb_idx;
    logic          arb_any;
    logic          xfer;
    logic          fft_valid;
    logic [3:0]    ready;
    logic [DW-1:0] fft_data_i;
    logic [DW-1:0] fft_data_q;

    rr_arb4 u_rr_arb4 (
        .req        (bus.i_req),
        .last       (last_q),
        .gnt_onehot (arb_onehot),
        .gnt_idx    (arb_idx),
        .any        (arb_any)
    );

    // Only the granted source's slice is ever selected, so X elsewhere cannot leak.
    assign xfer = (state_q == ST_STREAM) && bus.i_valid[src_q] && bus.i_fft_ready;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        src_d      = src_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        fft_valid  = 1'b0;
        ready      = '0;
        fft_data_i = '0;
        fft_data_q = '0;
        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    grant_d = arb_onehot;
                    src_d   = arb_idx;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: state_d = ST_STREAM;
            ST_STREAM: begin
                fft_valid     = bus.i_valid[src_q];
                ready[src_q]  = bus.i_fft_ready;
                fft_data_i    = bus.i_data_i[src_q*DW +: DW];
                fft_data_q    = bus.i_data_q[src_q*DW +: DW];
                if (xfer) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        last_d  = src_q;
                        grant_d = '0;
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            src_q   <= '0;
            last_q  <= 2'd3;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            src_q   <= src_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.o_ready      = ready;
    assign bus.o_grant      = grant_q;
    assign bus.o_fft_valid  = fft_valid;
    assign bus.o_fft_data_i = fft_data_i;
    assign bus.o_fft_data_q = fft_data_q;
    assign bus.o_frame_src  = src_q;
    assign bus.o_frame_done = (state_q == ST_DONE);
    assign bus.o_busy       = (state_q == ST_GRANT) || (state_q == ST_STREAM);
endmodule

// File: tb/tb_fft_frame_arbiter.sv
// Scoreboard bench for fft_frame_arbiter with NFFT=8: drivers queue expected samples, a monitor checks them.
module tb_fft_frame_arbiter;
    localparam int SB = 3;
    localparam int DW = 16;
    localparam int NF = 8;

    logic i_clk   = 1'b0;
    logic i_reset = 1'b1;

    fft_frame_arbiter_if #(.DATA_FFT_SIZE(DW)) bus ();

    fft_frame_arbiter #(.SIZE_BUFFER(SB), .DATA_FFT_SIZE(DW)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int        src;
        logic [15:0] di;
        logic [15:0] dq;
    } samp_t;

    samp_t exp_q[$];
    int    exp_done_q[$];
    int    checks     = 0;
    int    failures   = 0;
    int    active_src = -1;
    bit    mon_en     = 1'b0;
    bit    x_mode     = 1'b0;
    bit    prev_busy  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compares DUT outputs against the bench's own expectations on every falling edge.
    always @(negedge i_clk) begin
        if (mon_en) begin
            automatic bit         stream = bus.o_busy && prev_busy;
            automatic logic [3:0] exp_ready = '0;
            automatic samp_t      s;
            automatic int         d;
            prev_busy = bus.o_busy;
            if (stream) begin
                if (active_src < 0) begin
                    check("stream_without_frame", 1, 0);
                end else begin
                    exp_ready[active_src] = bus.i_fft_ready;
                    check("fft_valid", bus.o_fft_valid, bus.i_valid[active_src]);
                end
                check("fft_data_known", $isunknown({bus.o_fft_data_i, bus.o_fft_data_q}), 0);
            end else begin
                check("idle_fft_valid", bus.o_fft_valid, 0);
                check("idle_fft_data", {bus.o_fft_data_i, bus.o_fft_data_q}, 0);
            end
            check("ready", bus.o_ready, exp_ready);
            if (bus.o_fft_valid === 1'b1 && bus.i_fft_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_sample", 1, 0);
                end else begin
                    s = exp_q.pop_front();
                    check("sample_i", bus.o_fft_data_i, s.di);
                    check("sample_q", bus.o_fft_data_q, s.dq);
                    check("sample_src", bus.o_frame_src, s.src);
                    check("sample_grant", bus.o_grant, 4'b0001 << s.src);
                end
            end
            if (bus.o_frame_done === 1'b1) begin
                if (exp_done_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    d = exp_done_q.pop_front();
                    check("done_src", bus.o_frame_src, d);
                    check("done_grant", bus.o_grant, 0);
                    check("done_busy", bus.o_busy, 0);
                end
            end
        end
    end

    task automatic drive_idle();
        bus.i_valid  = x_mode ? 4'bxxxx : 4'b0000;
        bus.i_data_i = x_mode ? 'x : '0;
        bus.i_data_q = x_mode ? 'x : '0;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        drive_idle();
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        active_src = -1;
        check("reset_outputs", {bus.o_grant, bus.o_ready, bus.o_busy, bus.o_frame_done,
                                bus.o_frame_src, bus.o_fft_valid}, 0);
        check("reset_data", {bus.o_fft_data_i, bus.o_fft_data_q}, 0);
    endtask

    // Runs one frame of source s; abort_at>0 asserts reset after that many transfers.
    task automatic run_frame(input int s, input int base, input bit stall,
                             input int drop_req_at, input int abort_at);
        int        n   = (abort_at > 0) ? abort_at : NF;
        int        xf  = 0;
        int        cyc = 0;
        int        gap = 0;
        int        wt  = 0;
        logic      vs;
        logic [3:0] v;
        logic [4*DW-1:0] di, dq;
        for (int k = 0; k < n; k++)
            exp_q.push_back('{s, 16'(base + k), 16'h8000 | 16'(base + k)});
        if (abort_at == 0) exp_done_q.push_back(s);
        while (bus.o_grant !== (4'b0001 << s) && wt < 20) begin
            @(posedge i_clk); #1;
            wt++;
        end
        check("grant_wait", bus.o_grant, 4'b0001 << s);
        active_src = s;
        while (xf < n && cyc < 200) begin
            vs = !(stall && xf == 3 && gap < 3);
            v  = x_mode ? 4'bxxxx : 4'b0000;
            di = x_mode ? 'x : '0;
            dq = x_mode ? 'x : '0;
            v[s] = vs;
            di[s*DW +: DW] = 16'(base + xf);
            dq[s*DW +: DW] = 16'h8000 | 16'(base + xf);
            bus.i_valid     = v;
            bus.i_data_i    = di;
            bus.i_data_q    = dq;
            bus.i_fft_ready = stall ? (cyc % 2 == 0) : 1'b1;
            @(negedge i_clk);
            if (vs && bus.o_ready[s] === 1'b1) xf++;
            else if (!vs) gap++;
            @(posedge i_clk); #1;
            cyc++;
            if (drop_req_at > 0 && xf == drop_req_at) bus.i_req = 4'b1101;
        end
        check("frame_transfers", xf, n);
        drive_idle();
        bus.i_fft_ready = 1'b1;
        if (abort_at > 0) begin
            do_reset();
        end else begin
            active_src = -1;
        end
    endtask

    initial begin
        bus.i_req       = 4'b0000;
        bus.i_fft_ready = 1'b1;
        drive_idle();
        @(posedge i_clk); #1;
        do_reset();
        mon_en = 1'b1;

        // 1: single source, grant latency, I=1..8.
        bus.i_req = 4'b0001;
        @(posedge i_clk); #1;
        check("grant_latency", bus.o_grant, 4'b0001);
        check("grant_busy", bus.o_busy, 1);
        run_frame(0, 1, 1'b0, 0, 0);
        bus.i_req = 4'b0000;
        repeat (3) @(posedge i_clk);
        #1 check("busy_after_frame", bus.o_busy, 0);

        // 2: all request, round-robin order 0..3 from reset.
        do_reset();
        bus.i_req = 4'b1111;
        for (int s = 0; s < 4; s++) run_frame(s, 16 * (s + 1), 1'b0, 0, 0);

        // 3: stalls on src0 (pointer now 3).
        run_frame(0, 100, 1'b1, 0, 0);
        bus.i_req = 4'b0000;

        // 4: src1 drops its request after 2 samples; src2 follows.
        repeat (2) @(posedge i_clk); #1;
        bus.i_req = 4'b0010;
        run_frame(1, 200, 1'b0, 2, 0);
        run_frame(2, 300, 1'b0, 0, 0);

        // 5: reset at sample 5 of src3's frame, then src0 wins.
        bus.i_req = 4'b1111;
        run_frame(3, 400, 1'b0, 0, 5);
        run_frame(0, 500, 1'b0, 0, 0);

        // 6: X on non-granted sources.
        x_mode = 1'b1;
        drive_idle();
        run_frame(1, 600, 1'b0, 0, 0);
        run_frame(2, 700, 1'b1, 0, 0);
        bus.i_req = 4'b0000;
        repeat (5) @(posedge i_clk);
        #1;
        check("exp_samples_left", exp_q.size(), 0);
        check("exp_done_left", exp_done_q.size(), 0);
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
